// File: rtl/alu_pkg.sv
// Shared encodings for the ALU decode path.
// Contents: ALUctrl codes, RV32I opcode constants, ResultSrc codes, the
// immediate format enum, and the funct3 -> ALUctrl map used by R- and I-ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_PASS = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b101;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  // Returns {supported, alu_ctrl} for the arithmetic funct3 values we implement.
  function automatic logic [3:0] alu_f3_map(input logic [2:0] f3);
    logic [3:0] r;
    r = {1'b0, ALU_ADD};
    case (f3)
      3'b000:  r = {1'b1, ALU_ADD};
      3'b111:  r = {1'b1, ALU_AND};
      3'b110:  r = {1'b1, ALU_OR};
      3'b010:  r = {1'b1, ALU_SLT};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_decode_stage_imm_ext.sv
// imm_ext: combinational immediate extractor, reused by later stages.
// Ports:
//   in_instr  [DATA_WIDTH]  raw instruction (RV32I fields in bits 31:0)
//   imm_type                immediate format to extract
//   imm       [DATA_WIDTH]  sign-extended immediate
module imm_ext
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  imm_type_e             imm_type,
  output logic [DATA_WIDTH-1:0] imm
);

  logic [31:0] i;
  logic [31:0] imm32;

  assign i = in_instr[31:0];

  // Every format takes its sign from i[31]; build the 32-bit value first,
  // then widen by signed cast so wider datapaths still sign-extend.
  always_comb begin
    imm32 = {{20{i[31]}}, i[31:20]};
    case (imm_type)
      IMM_I:   imm32 = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm32 = {i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm32 = {{20{i[31]}}, i[31:20]};
    endcase
  end

  assign imm = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered RV32I decode stage feeding the ALU and the
// mem/writeback logic. One-entry output register with valid/ready
// backpressure and flush.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          upstream handshake; in_instr, in_pc payload
//   flush                      drops held and incoming instruction
//   out_valid/out_ready        downstream handshake
//   out_pc, ALUctrl, ALUsrc, imm, RegWrite, MemWrite, ResultSrc,
//   Branch, BranchNe, Jump, rs1, rs2, rd, illegal   registered decode bundle
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_instr,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_pc,
  output logic [2:0]                ALUctrl,
  output logic                      ALUsrc,
  output logic [DATA_WIDTH-1:0]     imm,
  output logic                      RegWrite,
  output logic                      MemWrite,
  output logic [1:0]                ResultSrc,
  output logic                      Branch,
  output logic                      BranchNe,
  output logic                      Jump,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic                      illegal
);

  logic       accept;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] f3map;

  logic [2:0]            dec_alu;
  logic                  dec_src, dec_rw, dec_mw, dec_br, dec_bne, dec_j, dec_ill;
  logic [1:0]            dec_res;
  imm_type_e             dec_imm_type;
  logic [DATA_WIDTH-1:0] dec_imm;

  logic                      out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]     pc_q, imm_q;
  logic [2:0]                alu_q;
  logic                      src_q, rw_q, mw_q, br_q, bne_q, j_q, ill_q;
  logic [1:0]                res_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign f3map  = alu_f3_map(funct3);

  // Flush blocks acceptance here, which also gives it priority over accept.
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Enables are raised only on legal paths, so an illegal encoding
  // naturally leaves RegWrite/MemWrite/Branch/Jump at 0 and ALUctrl at add.
  always_comb begin
    dec_alu      = ALU_ADD;
    dec_src      = 1'b0;
    dec_rw       = 1'b0;
    dec_mw       = 1'b0;
    dec_res      = RES_ALU;
    dec_br       = 1'b0;
    dec_bne      = 1'b0;
    dec_j        = 1'b0;
    dec_ill      = 1'b0;
    dec_imm_type = IMM_I;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000 && f3map[3]) begin
          dec_alu = f3map[2:0];
          dec_rw  = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_I: begin
        if (f3map[3]) begin
          dec_alu = f3map[2:0];
          dec_src = 1'b1;
          dec_rw  = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          dec_src = 1'b1;
          dec_rw  = 1'b1;
          dec_res = RES_MEM;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_STORE: begin
        dec_imm_type = IMM_S;
        if (funct3 == 3'b010) begin
          dec_src = 1'b1;
          dec_mw  = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_BRANCH: begin
        dec_imm_type = IMM_B;
        if (funct3[2:1] == 2'b00) begin
          dec_br  = 1'b1;
          dec_bne = funct3[0];
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_LUI: begin
        dec_imm_type = IMM_U;
        dec_alu      = ALU_PASS;
        dec_src      = 1'b1;
        dec_rw       = 1'b1;
      end
      OP_JAL: begin
        dec_imm_type = IMM_J;
        dec_j        = 1'b1;
        dec_rw       = 1'b1;
        dec_res      = RES_PC4;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  imm_ext #(.DATA_WIDTH(DATA_WIDTH)) u_imm_ext (
    .in_instr (in_instr),
    .imm_type (dec_imm_type),
    .imm      (dec_imm)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      alu_q       <= '0;
      src_q       <= 1'b0;
      rw_q        <= 1'b0;
      mw_q        <= 1'b0;
      res_q       <= '0;
      br_q        <= 1'b0;
      bne_q       <= 1'b0;
      j_q         <= 1'b0;
      ill_q       <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        pc_q  <= in_pc;
        imm_q <= dec_imm;
        alu_q <= dec_alu;
        src_q <= dec_src;
        rw_q  <= dec_rw;
        mw_q  <= dec_mw;
        res_q <= dec_res;
        br_q  <= dec_br;
        bne_q <= dec_bne;
        j_q   <= dec_j;
        ill_q <= dec_ill;
        rs1_q <= in_instr[15 +: REG_ADDR_WIDTH];
        rs2_q <= in_instr[20 +: REG_ADDR_WIDTH];
        rd_q  <= in_instr[7 +: REG_ADDR_WIDTH];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = pc_q;
  assign imm       = imm_q;
  assign ALUctrl   = alu_q;
  assign ALUsrc    = src_q;
  assign RegWrite  = rw_q;
  assign MemWrite  = mw_q;
  assign ResultSrc = res_q;
  assign Branch    = br_q;
  assign BranchNe  = bne_q;
  assign Jump      = j_q;
  assign illegal   = ill_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic [31:0] imm;
  logic        RegWrite;
  logic        MemWrite;
  logic [1:0]  ResultSrc;
  logic        Branch;
  logic        BranchNe;
  logic        Jump;
  logic [4:0]  rs1, rs2, rd;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .imm(imm), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ResultSrc(ResultSrc), .Branch(Branch),
    .BranchNe(BranchNe), .Jump(Jump), .rs1(rs1), .rs2(rs2), .rd(rd),
    .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accepting cycle, then idle the input.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Check the control bundle: {ALUctrl, ALUsrc, RegWrite, MemWrite, ResultSrc, Branch, BranchNe, Jump, illegal}
  task automatic chk_ctrl(input string tag, input logic [2:0] alu, input logic src,
                          input logic rw, input logic mw, input logic [1:0] res,
                          input logic br, input logic bne, input logic j, input logic ill);
    chk({tag, ".ctrl"}, {20'b0, ALUctrl, ALUsrc, RegWrite, MemWrite, ResultSrc, Branch, BranchNe, Jump, illegal},
        {20'b0, alu, src, rw, mw, res, br, bne, j, ill});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst.imm", imm, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // add x3,x1,x2
    issue(32'h002081B3, 32'h0000_1000);
    chk("add.valid", {31'b0, out_valid}, 32'd1);
    chk_ctrl("add", 3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add.regs", {17'b0, rs1, rs2, rd}, {17'b0, 5'd1, 5'd2, 5'd3});
    chk("add.pc", out_pc, 32'h0000_1000);

    // addi x1,x0,-1
    issue(32'hFFF00093, 32'h0000_1004);
    chk("addi.imm", imm, 32'hFFFF_FFFF);
    chk_ctrl("addi", 3'b000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("addi.rd", {27'b0, rd}, 32'd1);

    // lui x5,0x12345
    issue(32'h123452B7, 32'h0000_1008);
    chk("lui.imm", imm, 32'h1234_5000);
    chk_ctrl("lui", 3'b001, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // beq x1,x2,-4
    issue(32'hFE208EE3, 32'h0000_100C);
    chk("beq.imm", imm, 32'hFFFF_FFFC);
    chk_ctrl("beq", 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // branch with i[7]=0: B-imm bit 11 clear -> -2052
    issue(32'hFE208E63, 32'h0000_1010);
    chk("beq2.imm", imm, 32'hFFFF_F7FC);

    // bne x1,x2,-4
    issue(32'hFE209EE3, 32'h0000_1014);
    chk_ctrl("bne", 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);

    // sw x2,8(x1)
    issue(32'h0020A423, 32'h0000_1018);
    chk("sw.imm", imm, 32'd8);
    chk_ctrl("sw", 3'b000, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // lw x4,-8(x2)
    issue(32'hFF812203, 32'h0000_101C);
    chk("lw.imm", imm, 32'hFFFF_FFF8);
    chk_ctrl("lw", 3'b000, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

    // jal x1,8
    issue(32'h008000EF, 32'h0000_1020);
    chk("jal.imm", imm, 32'd8);
    chk_ctrl("jal", 3'b000, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);

    // slt x3,x1,x2 and ori x1,x1,0xFF
    issue(32'h0020A1B3, 32'h0000_1024);
    chk_ctrl("slt", 3'b101, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h0FF0E093, 32'h0000_1028);
    chk("ori.imm", imm, 32'h0000_00FF);
    chk_ctrl("ori", 3'b011, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // sub (funct7=0100000) and the all-ones opcode are unsupported
    issue(32'h402081B3, 32'h0000_102C);
    chk("sub.valid", {31'b0, out_valid}, 32'd1);
    chk_ctrl("sub", 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h0000007F, 32'h0000_1030);
    chk("ill.valid", {31'b0, out_valid}, 32'd1);
    chk_ctrl("ill", 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    // drain with nothing incoming
    tick();
    chk("drain.valid", {31'b0, out_valid}, 32'd0);
    chk("drain.hold_ill", {31'b0, illegal}, 32'd1);

    // Backpressure: add held while addi waits
    @(negedge clk);
    out_ready = 1'b0;
    issue(32'h002081B3, 32'h0000_2000);
    chk("bp.valid0", {31'b0, out_valid}, 32'd1);
    in_instr = 32'hFFF00093; in_pc = 32'h0000_2004; in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      chk("bp.in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("bp.valid", {31'b0, out_valid}, 32'd1);
      chk("bp.rd", {27'b0, rd}, 32'd3);
      chk("bp.pc", out_pc, 32'h0000_2000);
      chk("bp.imm", imm, 32'h0000_0002);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_up", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.addi_valid", {31'b0, out_valid}, 32'd1);
    chk("bp.addi_pc", out_pc, 32'h0000_2004);
    chk("bp.addi_imm", imm, 32'hFFFF_FFFF);
    tick();
    chk("bp.no_dup", {31'b0, out_valid}, 32'd0);

    // Flush with a held bundle and a valid incoming instruction
    @(negedge clk);
    out_ready = 1'b0;
    issue(32'h002081B3, 32'h0000_3000);
    chk("fl.held", {31'b0, out_valid}, 32'd1);
    in_instr = 32'h123452B7; in_pc = 32'h0000_3004; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("fl.in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.valid", {31'b0, out_valid}, 32'd0);
    chk("fl.dropped_pc", out_pc, 32'h0000_3000);
    tick();
    chk("fl.stays_empty", {31'b0, out_valid}, 32'd0);

    // Reset mid-stall
    issue(32'h123452B7, 32'h0000_4000);
    tick();
    chk("rs.stalled", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs.valid", {31'b0, out_valid}, 32'd0);
    chk("rs.imm", imm, 32'd0);
    chk("rs.pc", out_pc, 32'd0);
    chk_ctrl("rs", 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rs.in_ready", {31'b0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
